x74xx_gate_bank_pipe: RTL

// Parametrised successor to the single-function quad 2-input gate models.

---
 rtl/x74xx_gate_bank_pipe_if.sv | 29 ++
 rtl/x74xx_gate_bank_pipe.sv | 87 ++++++++
 2 files changed

// File: rtl/x74xx_gate_bank_pipe_if.sv
// Gate bank bus: per-beat operands/opcode in, gated result, valid and activity count out.
// master drives the beat and control inputs; slave is the gate bank itself.
interface x74xx_gate_bank_pipe_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 1,
    parameter int CNT_W    = 16
);
    localparam int N = CHANNELS * WIDTH;

    logic [1:0]       op;
    logic             in_valid;
    logic             hold;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [N-1:0]     y;
    logic             out_valid;
    logic             cnt_clear;
    logic [CNT_W-1:0] toggle_count;

    modport master (
        output op, in_valid, hold, a, b, cnt_clear,
        input  y, out_valid, toggle_count
    );

    modport slave (
        input  op, in_valid, hold, a, b, cnt_clear,
        output y, out_valid, toggle_count
    );
endinterface

// File: rtl/x74xx_gate_bank_pipe.sv
// Bank of bitwise 2-input gates (OR/AND/XOR/NOR) behind a STAGES-deep pipeline (0 = combinational).
// Latency STAGES edges; hold freezes every stage and drops the offered beat; no queuing.
module x74xx_gate_bank_pipe #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 1,
    parameter int STAGES   = 1,
    parameter int CNT_W    = 16
) (
    input  logic                  clock_50,
    input  logic                  reset,
    x74xx_gate_bank_pipe_if.slave bus
);
    localparam int N = CHANNELS * WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0]     y_int;
    logic             vld_int;
    logic [N-1:0]     last_y;
    logic [CNT_W-1:0] toggle_cnt;

    function automatic logic [N-1:0] gate_f(input logic [1:0] op,
                                            input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        logic [N-1:0] r;
        case (op)
            2'b00:   r = a | b;
            2'b01:   r = a & b;
            2'b10:   r = a ^ b;
            default: r = ~(a | b);
        endcase
        return r;
    endfunction

    if (STAGES == 0) begin : g_comb
        assign y_int   = gate_f(bus.op, bus.a, bus.b);
        assign vld_int = bus.in_valid & ~bus.hold;
    end else begin : g_pipe
        logic [N-1:0]      pipe_dat [STAGES];
        logic [STAGES-1:0] pipe_vld;

        // Data only moves with a valid beat, so bubbles leave y at the last result.
        always_ff @(posedge clock_50) begin
            if (reset) begin
                for (int k = 0; k < STAGES; k++) begin
                    pipe_dat[k] <= '0;
                end
                pipe_vld <= '0;
            end else if (!bus.hold) begin
                pipe_vld[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    pipe_dat[0] <= gate_f(bus.op, bus.a, bus.b);
                end
                for (int k = 1; k < STAGES; k++) begin
                    pipe_vld[k] <= pipe_vld[k-1];
                    if (pipe_vld[k-1]) begin
                        pipe_dat[k] <= pipe_dat[k-1];
                    end
                end
            end
        end

        assign y_int   = pipe_dat[STAGES-1];
        assign vld_int = pipe_vld[STAGES-1];
    end

    // A frozen output under hold is not a new observation, so it is not counted.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            last_y     <= '0;
            toggle_cnt <= '0;
        end else begin
            if (vld_int && !bus.hold) begin
                last_y <= y_int;
                if ((y_int != last_y) && (toggle_cnt != CNT_MAX)) begin
                    toggle_cnt <= toggle_cnt + 1'b1;
                end
            end
            if (bus.cnt_clear) begin
                toggle_cnt <= '0;
            end
        end
    end

    assign bus.y            = y_int;
    assign bus.out_valid    = vld_int;
    assign bus.toggle_count = toggle_cnt;
endmodule
